apb4_master_arbiter: RTL and testbench

- Shares one APB4 master port between NUM_REQ local requesters (e.g. debug bridge, boot sequencer, CPU shim) that access APB4 slaves such as apb4_archinfo.
- Round-robin arbitration; one transfer in flight.
- Drives the full APB4 SETUP/ACCESS protocol and returns read data and error to the granted requester.
- Optional watchdog ends a stalled transfer with an error.

---
 rtl/apb4_master_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_apb4_master_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master_arbiter.sv
// apb4_master_arbiter: shares one APB4 master port between NUM_REQ local
// requesters. Round-robin arbitration with a single transfer in flight and an
// optional ACCESS-phase watchdog that ends a stalled transfer with an error.
//
// Command handshake: a command moves from requester k when req_valid_i[k] and
// req_ready_o[k] are both high in the same cycle. req_ready_o is only ever
// raised in IDLE, at most one bit at a time, and the requester's fields are
// sampled in that cycle only. Responses are a one-cycle rsp_valid_o pulse to
// the owner with no backpressure.
module apb4_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ-1:0]                req_write_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic [ADDR_WIDTH-1:0]             paddr_o,
  output logic [2:0]                        pprot_o,
  output logic                              psel_o,
  output logic                              penable_o,
  output logic                              pwrite_o,
  output logic [DATA_WIDTH-1:0]             pwdata_o,
  output logic [DATA_WIDTH/8-1:0]           pstrb_o,
  input  logic [DATA_WIDTH-1:0]             prdata_i,
  input  logic                              pready_i,
  input  logic                              pslverr_i,
  output logic [1:0]                        dbg_state_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     strb_q, strb_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant_found;
  logic [GW-1:0]     grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic              sel_write;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]     sel_strb;

  // Round-robin pick: lowest valid index above last_grant, else lowest overall.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid_i[j] && (GW'(j) <= last_grant_q)) begin
        grant_found = 1'b1;
        grant_idx   = GW'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid_i[j] && (GW'(j) > last_grant_q)) begin
        grant_found = 1'b1;
        grant_idx   = GW'(j);
      end
    end
  end

  // Select the winning requester's command fields from the packed buses.
  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (GW'(j) == grant_idx) begin
        sel_addr  = req_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write = req_write_i[j];
        sel_wdata = req_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb_i[j*SW +: SW];
      end
    end
  end

  // Accept is combinational and only possible while idle.
  always_comb begin
    req_ready_o = '0;
    if ((state_q == ST_IDLE) && grant_found) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // FSM next state, command capture, APB phase control and response build.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          addr_d       = sel_addr;
          write_d      = sel_write;
          wdata_d      = sel_wdata;
          strb_d       = sel_write ? sel_strb : '0;
          psel_d       = 1'b1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = write_q ? '0 : prdata_i;
          rsp_err_d            = pslverr_i;
          cnt_d                = '0;
          state_d              = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Watchdog expiry: abandon the slave and report an error.
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          cnt_d                = '0;
          state_d              = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset aborts any transfer silently.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_INIT;
      owner_q      <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign paddr_o     = addr_q;
  assign pprot_o     = 3'b000;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Bench for apb4_master_arbiter: directed plan steps followed by randomized
// transfers, each checked against a transaction-level model of arbitration,
// APB phase timing, watchdog and response contents.
module tb_apb4_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [AW-1:0]   a_f[N];
  logic            w_f[N];
  logic [DW-1:0]   d_f[N];
  logic [SW-1:0]   s_f[N];
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  logic [N-1:0]  req_ready_o, rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o, pwdata_o;
  logic          rsp_err_o, psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [2:0]    pprot_o;
  logic [SW-1:0] pstrb_o;
  logic [1:0]    dbg_state_o;

  assign req_addr  = {a_f[1], a_f[0]};
  assign req_write = {w_f[1], w_f[0]};
  assign req_wdata = {d_f[1], d_f[0]};
  assign req_strb  = {s_f[1], s_f[0]};

  apb4_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr), .req_write_i(req_write),
    .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .dbg_state_o(dbg_state_o)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int last_grant;
  logic [DW-1:0] last_rdata;
  logic          last_err;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: first valid requester after last_grant, wrapping.
  function automatic int model_grant(input logic [N-1:0] v);
    logic [N-1:0] sh;
    for (int i = 1; i <= N; i++) begin
      int c;
      c  = (last_grant + i) % N;
      sh = v >> c;
      if (sh[0]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [AW-1:0] ad, input logic wr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st);
    a_f[k] = ad; w_f[k] = wr; d_f[k] = wd; s_f[k] = st;
  endtask

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      set_req(k, $urandom, 1'($urandom_range(0, 1)), $urandom, SW'($urandom));
    end
  endtask

  task automatic check_rsp_hold(input string tag);
    chk({tag, "_rdata_hold"}, 64'(rsp_rdata_o), 64'(last_rdata));
    chk({tag, "_err_hold"}, 64'(rsp_err_o), 64'(last_err));
  endtask

  // Driver: quiet cycles with no requests.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = '0;
      @(negedge clk);
      #1;
      chk("idle_ready", 64'(req_ready_o), 64'(0));
      chk("idle_rsp", 64'(rsp_valid_o), 64'(0));
      chk("idle_psel", 64'(psel_o), 64'(0));
      check_rsp_hold("idle");
    end
  endtask

  // Driver + checker for one complete transfer. Entered and left at a
  // negedge while the DUT is idle; the request is presented in that cycle.
  task automatic xfer(input logic [N-1:0] v, input bit hold, input int waits,
                      input logic serr, input logic [DW-1:0] rd);
    int g, w;
    bit done, tmo;
    logic [N-1:0]  oh;
    logic [AW-1:0] e_addr;
    logic          e_w;
    logic [DW-1:0] e_wd, e_rd;
    logic [SW-1:0] e_s;
    g = model_grant(v);
    oh = N'(1) << g;
    req_valid = v;
    #1;
    chk("ready_grant", 64'(req_ready_o), 64'(oh));
    e_addr = a_f[g]; e_w = w_f[g]; e_wd = d_f[g];
    e_s = e_w ? s_f[g] : '0;
    last_grant = g;
    // SETUP cycle
    @(negedge clk);
    if (!hold) req_valid = '0;
    scramble();
    #1;
    chk("setup_psel", 64'(psel_o), 64'(1));
    chk("setup_penable", 64'(penable_o), 64'(0));
    chk("setup_paddr", 64'(paddr_o), 64'(e_addr));
    chk("setup_pwrite", 64'(pwrite_o), 64'(e_w));
    chk("setup_pwdata", 64'(pwdata_o), 64'(e_wd));
    chk("setup_pstrb", 64'(pstrb_o), 64'(e_s));
    chk("setup_ready", 64'(req_ready_o), 64'(0));
    chk("setup_rsp", 64'(rsp_valid_o), 64'(0));
    chk("pprot", 64'(pprot_o), 64'(0));
    // ACCESS cycles; at most TO of them
    w = 0; done = 0; tmo = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      chk("acc_psel", 64'(psel_o), 64'(1));
      chk("acc_penable", 64'(penable_o), 64'(1));
      chk("acc_paddr", 64'(paddr_o), 64'(e_addr));
      chk("acc_pwdata", 64'(pwdata_o), 64'(e_wd));
      chk("acc_pstrb", 64'(pstrb_o), 64'(e_s));
      chk("acc_pwrite", 64'(pwrite_o), 64'(e_w));
      chk("acc_ready", 64'(req_ready_o), 64'(0));
      chk("acc_rsp", 64'(rsp_valid_o), 64'(0));
      if (w == waits) begin
        pready = 1'b1; pslverr = serr; prdata = rd; done = 1;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
        if (w == TO - 1) begin tmo = 1; done = 1; end
      end
      w++;
    end
    // Response cycle
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    #1;
    if (tmo) begin
      e_rd = '0; last_err = 1'b1;
    end else begin
      e_rd = e_w ? '0 : rd; last_err = serr;
    end
    exp_q.push_back(e_rd);
    last_rdata = exp_q.pop_front();
    chk("rsp_valid", 64'(rsp_valid_o), 64'(oh));
    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(last_rdata));
    chk("rsp_err", 64'(rsp_err_o), 64'(last_err));
    chk("rsp_psel", 64'(psel_o), 64'(0));
    chk("rsp_penable", 64'(penable_o), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'(0));
    chk({tag, "_rsp"}, 64'(rsp_valid_o), 64'(0));
    chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(0));
    chk({tag, "_err"}, 64'(rsp_err_o), 64'(0));
    chk({tag, "_paddr"}, 64'(paddr_o), 64'(0));
    chk({tag, "_psel"}, 64'(psel_o), 64'(0));
    chk({tag, "_penable"}, 64'(penable_o), 64'(0));
    chk({tag, "_pwrite"}, 64'(pwrite_o), 64'(0));
    chk({tag, "_pwdata"}, 64'(pwdata_o), 64'(0));
    chk({tag, "_pstrb"}, 64'(pstrb_o), 64'(0));
    chk({tag, "_pprot"}, 64'(pprot_o), 64'(0));
  endtask

  // Global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // Directed and randomized sequence
  initial begin
    req_valid = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    for (int k = 0; k < N; k++) set_req(k, '0, 1'b0, '0, '0);
    last_grant = N - 1; last_rdata = '0; last_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Single zero-wait read from requester 0
    set_req(0, 32'h0000_0004, 1'b0, 32'h0, 4'hF);
    xfer(2'b01, 0, 0, 1'b0, 32'hDEAD_BEEF);
    idle(1);

    // Write with strobes and 3 wait states from requester 1
    set_req(1, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011);
    xfer(2'b10, 0, 3, 1'b0, 32'hCAFE_F00D);
    idle(1);

    // Contention: both valid throughout, expect 0,1,0,1
    for (int i = 0; i < 4; i++) xfer(2'b11, 1, $urandom_range(0, 2), 1'b0, $urandom);
    idle(1);

    // Slave error, owner only
    xfer(2'b01, 0, 1, 1'b1, $urandom);
    xfer(2'b10, 0, 0, 1'b1, $urandom);
    idle(2);

    // Watchdog expiry, then pready on the last allowed ACCESS cycle
    xfer(2'b01, 0, 1000, 1'b0, $urandom);
    idle(1);
    xfer(2'b10, 0, TO - 1, 1'b0, 32'h5A5A_A5A5);
    xfer(2'b01, 0, TO - 2, 1'b0, 32'h0F0F_1234);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      xfer(N'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom);
      idle($urandom_range(0, 2));
    end

    // Reset during ACCESS: requester 1 granted, then reset mid-wait
    idle(1);
    if (model_grant(2'b10) != 1) begin
      // unreachable with two requesters; keeps the model honest
      last_grant = 0;
    end
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    pready = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_reset_penable", 64'(penable_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = N - 1; last_rdata = '0; last_err = 1'b0;
    idle(3);
    xfer(2'b11, 0, 0, 1'b0, 32'h1357_9BDF);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
